// File: rtl/k580_bus_arbiter.sv
// System controller for a K580 (8080-compatible) core: CPU clock-enable, status latch,
// and time-sharing of one 8-bit memory port between the CPU and a DMA/video requester.
module k580_bus_arbiter #(
  parameter int CE_DIV   = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_sync,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_inta,
  input  logic [7:0]  cpu_odata,
  output logic [7:0]  cpu_idata,
  input  logic [7:0]  intr_vec,
  output logic [7:0]  status,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [7:0]  io_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata
);

  localparam int CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [CNT_W-1:0] CE_LAST = CNT_W'(CE_DIV - 1);
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;
  typedef enum logic [2:0] {K_INTA, K_IORD, K_MEMRD, K_IOWR, K_MEMWR} kind_t;

  state_t           state_reg;
  kind_t            kind_reg;
  kind_t            kind_next;
  logic [2:0]       wait_reg;
  logic [CNT_W-1:0] ce_cnt_reg;
  logic             cpu_done_reg;
  logic             dma_we_reg;
  logic [7:0]       dma_rdata_reg;
  logic             cpu_pend;
  logic             stall;

  assign cpu_pend = (cpu_rd | cpu_wr | cpu_inta) & ~cpu_done_reg;
  assign stall    = cpu_pend | (state_reg != IDLE);
  assign cpu_ce   = (ce_cnt_reg == CE_LAST) & ~stall;

  // The requester sees read data in the very cycle dma_ack is high; it is held afterwards.
  assign dma_rdata = dma_ack ? mem_rdata : dma_rdata_reg;

  // INTA wins over the strobes; IO versus memory comes from the latched status byte.
  always_comb begin
    kind_next = K_MEMRD;
    if (cpu_inta)
      kind_next = K_INTA;
    else if (cpu_wr)
      kind_next = status[4] ? K_IOWR : K_MEMWR;
    else if (status[6])
      kind_next = K_IORD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      kind_reg      <= K_INTA;
      wait_reg      <= 3'd0;
      ce_cnt_reg    <= '0;
      cpu_done_reg  <= 1'b0;
      dma_we_reg    <= 1'b0;
      dma_rdata_reg <= 8'h00;
      cpu_idata     <= 8'h00;
      status        <= 8'h00;
      mem_addr      <= 16'h0000;
      mem_wdata     <= 8'h00;
      mem_oe        <= 1'b0;
      mem_we        <= 1'b0;
      io_rd         <= 1'b0;
      io_wr         <= 1'b0;
      dma_ack       <= 1'b0;
    end else begin
      io_rd   <= 1'b0;
      io_wr   <= 1'b0;
      dma_ack <= 1'b0;
      mem_we  <= 1'b0;

      // The counter parks on its last value while the CPU is stalled.
      if (ce_cnt_reg == CE_LAST) begin
        if (!stall)
          ce_cnt_reg <= '0;
      end else begin
        ce_cnt_reg <= ce_cnt_reg + 1'b1;
      end

      if (cpu_ce) begin
        cpu_done_reg <= 1'b0;
        if (cpu_sync)
          status <= cpu_odata;
      end

      case (state_reg)
        IDLE: begin
          if (cpu_pend) begin
            state_reg <= CPU_ACC;
            kind_reg  <= kind_next;
            wait_reg  <= (kind_next == K_INTA) ? 3'd0 : WAIT_INIT;
            if (kind_next == K_MEMRD || kind_next == K_MEMWR) begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_odata;
            end
            mem_oe <= (kind_next == K_MEMRD);
            mem_we <= (kind_next == K_MEMWR) && (WAIT_INIT == 3'd0);
            io_rd  <= (kind_next == K_IORD);
            io_wr  <= (kind_next == K_IOWR);
          end else if (dma_req) begin
            state_reg  <= DMA_ACC;
            wait_reg   <= WAIT_INIT;
            dma_we_reg <= dma_we;
            mem_addr   <= dma_addr;
            mem_wdata  <= dma_wdata;
            mem_oe     <= ~dma_we;
            mem_we     <= dma_we && (WAIT_INIT == 3'd0);
            dma_ack    <= (WAIT_INIT == 3'd0);
          end
        end

        CPU_ACC: begin
          if (wait_reg != 3'd0) begin
            wait_reg <= wait_reg - 3'd1;
            if (wait_reg == 3'd1)
              mem_we <= (kind_reg == K_MEMWR);
          end else begin
            state_reg    <= IDLE;
            mem_oe       <= 1'b0;
            cpu_done_reg <= 1'b1;
            case (kind_reg)
              K_INTA:  cpu_idata <= intr_vec;
              K_IORD:  cpu_idata <= io_rdata;
              K_MEMRD: cpu_idata <= mem_rdata;
              default: cpu_idata <= cpu_idata;
            endcase
          end
        end

        DMA_ACC: begin
          if (wait_reg != 3'd0) begin
            wait_reg <= wait_reg - 3'd1;
            if (wait_reg == 3'd1) begin
              mem_we  <= dma_we_reg;
              dma_ack <= 1'b1;
            end
          end else begin
            state_reg     <= IDLE;
            mem_oe        <= 1'b0;
            dma_rdata_reg <= mem_rdata;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/k580_bus_arbiter.md
Name: k580_bus_arbiter

Overview:
- System controller between the K580 (8080-compatible) CPU core and a single-port 8-bit memory.
- Generates the CPU clock-enable and latches the status byte the CPU drives on its data-out bus during sync.
- Decodes memory/IO/INTA cycles and time-shares the memory port with a DMA/video requester, stalling the CPU through its clock-enable when the port is busy.

Parameters:
CE_DIV, 4, clk cycles per CPU ce tick (>=3)
MEM_WAIT, 1, extra clk cycles a memory access occupies after address/strobe issue (0..7)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
cpu_ce  out  1  one-clk enable pulse to the CPU
cpu_addr  in  16  CPU address
cpu_sync  in  1  status phase; cpu_odata carries the status byte
cpu_rd  in  1  CPU read strobe (memory or IO)
cpu_wr  in  1  CPU write strobe
cpu_inta  in  1  interrupt-acknowledge read
cpu_odata  in  8  CPU status byte / write data
cpu_idata  out  8  read data to the CPU
intr_vec  in  8  opcode returned on INTA (e.g. RST n)
status  out  8  latched status byte
mem_addr  out  16  memory address
mem_wdata  out  8  memory write data
mem_oe  out  1  memory read enable
mem_we  out  1  memory write pulse
mem_rdata  in  8  memory read data
io_rd  out  1  one-clk IN strobe, address cpu_addr[7:0]
io_wr  out  1  one-clk OUT strobe
io_rdata  in  8  IO read data
dma_req  in  1  DMA/video access request, held until dma_ack
dma_we  in  1  DMA write (else read)
dma_addr  in  16  DMA address
dma_wdata  in  8  DMA write data
dma_ack  out  1  one-clk completion; dma_rdata valid this cycle
dma_rdata  out  8  DMA read data

Behaviour:

Reset values:
- All outputs are 0.
- FSM is IDLE; ce counter is 0; cpu_done is 0.
- Reset mid-access drops mem_we/mem_oe immediately. No ack is issued for the aborted DMA access.

CE generation:
- The counter runs 0..CE_DIV-1.
- cpu_ce=1 for one clk when counter==CE_DIV-1 and not stalled. The counter then wraps to 0.
- While stalled, the counter holds at CE_DIV-1 and cpu_ce stays 0.

Status latch:
- On a clk with cpu_ce=1 and cpu_sync=1, status<=cpu_odata. Held until the next sync.
- Bit map: 7 MEMR, 6 INP, 5 M1, 4 OUT, 3 HLTA, 2 STACK, 1 WO_n, 0 INTA.

CPU request:
- cpu_rd, cpu_wr and cpu_inta change only on ce ticks.
- A CPU request is pending when (cpu_rd|cpu_wr|cpu_inta) & ~cpu_done.
- cpu_done is set when the CPU access completes and cleared on every cpu_ce. Each CPU strobe period is therefore serviced exactly once.

Stall:
- stall = CPU request pending, or FSM not in IDLE.
- The data the CPU samples at its next ce is always complete.

FSM states: IDLE, CPU_ACC, DMA_ACC, each access lasting 1+MEM_WAIT clks (wait counter).
- IDLE → CPU_ACC when a CPU request is pending. CPU has priority over a simultaneous dma_req.
- IDLE → DMA_ACC when dma_req and no CPU request is pending.

Per CPU request type:
- cpu_inta: no memory access. cpu_idata<=intr_vec. Done after 1 clk.
- cpu_rd & status[6] (IN): io_rd=1 on the first clk; cpu_idata<=io_rdata on the last clk.
- cpu_rd otherwise (memory): mem_addr=cpu_addr, mem_oe=1 for the whole access; cpu_idata<=mem_rdata on the last clk.
- cpu_wr & status[4] (OUT): io_wr=1 for one clk. mem_we is not asserted.
- cpu_wr otherwise (memory): mem_addr=cpu_addr, mem_wdata=cpu_odata, mem_we=1 on the last clk only.

DMA_ACC:
- Same timing using dma_addr and dma_wdata.
- dma_rdata<=mem_rdata and dma_ack=1 on the last clk, then → IDLE.
- A DMA access is never pre-empted. A CPU request arriving mid-DMA waits, which stalls the CPU.

Other rules:
- cpu_idata holds its value between accesses.
- HLTA cycles (no strobes) generate no access; ce runs freely.
- dma_req re-asserted in the same clk as dma_ack is serviced on the next IDLE clk, behind any pending CPU request.

Test Plan:
- Reset then free run, no requests → cpu_ce pulses every 4 clks; all strobes 0; status=00.
- Sync tick with cpu_odata=A2, then memory read at addr 1234, mem_rdata=3E, MEM_WAIT=1 → status=A2; mem_oe 2 clks; cpu_idata=3E before next cpu_ce; exactly one access.
- Memory write addr 8000, data 55 → one mem_we pulse with mem_addr=8000, mem_wdata=55. Repeat with status=10 (OUT) → io_wr pulse only, no mem_we.
- INTA with intr_vec=FF → cpu_idata=FF; no mem_oe.
- dma_req held continuously; CPU reads each ce period → DMA acks interleave; cpu_ce period stretches to ≥ CE_DIV+2 when a DMA access is in flight at CPU request; no lost or duplicated accesses.
- Assert reset during DMA_ACC → mem_oe/mem_we drop asynchronously; no dma_ack; after release, a held dma_req is re-serviced.
